// File: rtl/pattern_det_fsm.sv
// Serial bit-pattern detector with a Moore match flag and a saturating
// match counter. The next-state table is elaborated from PATTERN and
// OVERLAP, so any legal pattern gets correct KMP-style fallback without
// hand-written transitions.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S0         | no useful prefix of PATTERN seen
// S1..S(W-1) | last k consumed bits equal the first k bits of PATTERN
// MATCH      | last W consumed bits equal PATTERN (index W), z=1
module pattern_det_fsm #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   PATTERN = 4'b1011,
    parameter int             OVERLAP = 1,
    parameter int             CNT_W   = 8,
    localparam int            PW      = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic             clr_cnt,
    output logic             z,
    output logic [PW-1:0]    progress,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    if (W < 2 || W > 16) begin : g_bad_w
        $error("pattern_det_fsm: W must be in 2..16");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("pattern_det_fsm: CNT_W must be in 1..32");
    end
    if (OVERLAP != 0 && OVERLAP != 1) begin : g_bad_overlap
        $error("pattern_det_fsm: OVERLAP must be 0 or 1");
    end

    localparam int               NS      = 2 ** PW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [PW-1:0] {
        S0    = '0,
        MATCH = PW'(W)
    } state_t;

    // Longest prefix of PATTERN that is a suffix of (first k pattern bits, b).
    // Leaving MATCH without overlap starts from an empty history instead.
    function automatic logic [PW-1:0] calc_next(input int k, input int b);
        logic [W:0] h;
        int         kk;
        int         len;
        int         best;
        logic       ok;
        h    = '0;
        best = 0;
        kk   = (k == W && OVERLAP == 0) ? 0 : k;
        if (k <= W) begin
            for (int i = 0; i < W; i++) begin
                if (i < kk) h[i] = PATTERN[W-1-i];
            end
            h[kk] = (b != 0);
            len   = kk + 1;
            for (int j = 1; j <= W; j++) begin
                if (j <= len) begin
                    ok = 1'b1;
                    for (int i = 0; i < W; i++) begin
                        if (i < j) begin
                            if (h[len-j+i] != PATTERN[W-1-i]) ok = 1'b0;
                        end
                    end
                    if (ok) best = j;
                end
            end
        end
        return PW'(best);
    endfunction

    // Unreachable encodings above MATCH map to S0 so the table is fully populated.
    logic [PW-1:0] nxt_tbl [2*NS];

    for (genvar k = 0; k < NS; k++) begin : g_state
        for (genvar b = 0; b < 2; b++) begin : g_bit
            localparam logic [PW-1:0] NXT = calc_next(k, b);
            assign nxt_tbl[2*k+b] = NXT;
        end
    end

    state_t           state;
    state_t           state_nxt;
    logic             enter_match;
    logic [CNT_W-1:0] cnt_inc;

    // State register; reset discards all partial progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S0;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state lookup on enabled samples; flags every edge that lands in MATCH.
    always_comb begin
        state_nxt   = state;
        enter_match = 1'b0;
        if (en) begin
            state_nxt   = state_t'(nxt_tbl[{state, x}]);
            enter_match = (state_nxt == MATCH);
        end
    end

    assign cnt_inc = match_cnt + CNT_W'(1);

    // Saturating match counter; clear wins over a simultaneous match.
    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else if (enter_match && (match_cnt != CNT_MAX)) begin
            match_cnt <= cnt_inc;
            cnt_sat   <= (cnt_inc == CNT_MAX);
        end
    end

    assign z        = (state == MATCH);
    assign progress = state;

endmodule
